// File: rtl/ysyx_22040895_mdu_iter.sv
// ysyx_22040895_mdu_iter: iterative RISC-V M-extension unit.
// Multiplies with a radix-2 shift-add loop and divides with a restoring loop,
// one result bit per cycle, on operand magnitudes; the sign fix-up is folded
// into the final iteration.
// Optional feature macro: YSYX_22040895_MDU_EARLY_OUT_EN -- when defined,
// divide-by-zero and signed-overflow requests skip the iteration loop.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE; result_o is zero whenever
// out_valid is low and holds stable in DONE until it is taken.
module ysyx_22040895_mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mduop_i,
    input  logic            wordop_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_MUL    = 4'd1;
    localparam logic [3:0] OP_MULH   = 4'd2;
    localparam logic [3:0] OP_MULHSU = 4'd3;
    localparam logic [3:0] OP_MULHU  = 4'd4;
    localparam logic [3:0] OP_DIV    = 4'd5;
    localparam logic [3:0] OP_DIVU   = 4'd6;
    localparam logic [3:0] OP_REM    = 4'd7;
    localparam logic [3:0] OP_REMU   = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Sign-extend a 32-bit value to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Request decode (combinational, from the input ports).
    logic            in_none, in_word, in_s1, in_s2, in_neg1, in_neg2;
    logic [XLEN-1:0] in_x1, in_x2, in_m1, in_m2;
    logic [CW-1:0]   in_n;

    // Captured request and iteration state.
    logic [3:0]        op_q;
    logic              word_q, neg1_q, neg2_q, dz_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier, rem_r, dq, dvsr, res_q;

    // One-iteration step and final-cycle result.
    logic [2*XLEN-1:0] acc_nx, prod_c;
    logic [XLEN:0]     r_sh;
    logic              ge, mul_neg, quo_neg;
    logic [XLEN-1:0]   rem_nx, dq_nx, quo_c, rmd_c, raw, fin;

    // Early-out detection; constant zero when the feature is compiled out.
    logic            early_hit;
    logic [XLEN-1:0] early_val;

    // Decode the incoming request: effective word mode, width N, magnitudes.
    always_comb begin
        in_none = (mduop_i == 4'd0) || (mduop_i > OP_REMU);
        // MULH/MULHSU/MULHU ignore wordop and always run full width.
        in_word = (XLEN == 64) && wordop_i &&
                  !(mduop_i inside {OP_MULH, OP_MULHSU, OP_MULHU});
        in_s1   = mduop_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        in_s2   = mduop_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        in_x1   = in_word ? (in_s1 ? sext32(op1_i[31:0]) : XLEN'(op1_i[31:0])) : op1_i;
        in_x2   = in_word ? (in_s2 ? sext32(op2_i[31:0]) : XLEN'(op2_i[31:0])) : op2_i;
        in_neg1 = in_s1 && in_x1[XLEN-1];
        in_neg2 = in_s2 && in_x2[XLEN-1];
        in_m1   = in_neg1 ? -in_x1 : in_x1;
        in_m2   = in_neg2 ? -in_x2 : in_x2;
        in_n    = in_word ? CW'(32) : CW'(XLEN);
    end

`ifdef YSYX_22040895_MDU_EARLY_OUT_EN
    logic            in_div, in_dz, in_ovf;
    logic [XLEN-1:0] most_neg;

    // Spot divide-by-zero and most-negative / -1 so they can finish at once.
    always_comb begin
        in_div    = mduop_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        most_neg  = in_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        in_dz     = in_div && (in_x2 == '0);
        in_ovf    = (mduop_i inside {OP_DIV, OP_REM}) && (in_x1 == most_neg) && (in_x2 == '1);
        early_hit = in_dz || in_ovf;
        early_val = '0;
        if (in_dz) begin
            if (mduop_i inside {OP_DIV, OP_DIVU}) early_val = '1;
            else                                  early_val = in_word ? sext32(in_x1[31:0]) : in_x1;
        end else if (in_ovf && (mduop_i == OP_DIV)) begin
            early_val = in_x1;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_val = '0;
`endif

    // One iteration of both loops; only the one matching op_q is consumed.
    always_comb begin
        acc_nx = mplier[0] ? (acc + mcand) : acc;
        r_sh   = {rem_r, dq[XLEN-1]};
        ge     = (r_sh >= {1'b0, dvsr});
        rem_nx = ge ? XLEN'(r_sh - {1'b0, dvsr}) : r_sh[XLEN-1:0];
        dq_nx  = {dq[XLEN-2:0], ge};
    end

    // Sign correction and result selection applied in the last CALC cycle.
    always_comb begin
        // MULHSU has neg2_q forced low, MULHU both, so XOR covers every MUL form.
        mul_neg = neg1_q ^ neg2_q;
        // Division by zero must give all ones, never a negated quotient.
        quo_neg = (neg1_q ^ neg2_q) && !dz_q;
        prod_c  = mul_neg ? -acc_nx : acc_nx;
        quo_c   = quo_neg ? -dq_nx : dq_nx;
        rmd_c   = neg1_q ? -rem_nx : rem_nx;
        case (op_q)
            OP_MUL:                      raw = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: raw = prod_c[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             raw = quo_c;
            default:                     raw = rmd_c;
        endcase
        fin = word_q ? sext32(raw[31:0]) : raw;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = (in_none || early_hit) ? S_DONE : S_CALC;
            S_CALC:  if (cnt == CW'(1)) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush_i) state_nx = S_IDLE;
    end

    // Handshake outputs, gated result and state visibility.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        result_o  = (state == S_DONE) ? res_q : '0;
        dbg_state = state;
    end

    // Datapath: capture on transfer, iterate in CALC, latch result at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            word_q <= 1'b0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            dz_q   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem_r  <= '0;
            dq     <= '0;
            dvsr   <= '0;
            res_q  <= '0;
        end else if (!flush_i) begin
            if ((state == S_IDLE) && in_valid) begin
                op_q   <= mduop_i;
                word_q <= in_word;
                neg1_q <= in_neg1;
                neg2_q <= in_neg2;
                dz_q   <= (in_x2 == '0);
                cnt    <= (in_none || early_hit) ? '0 : in_n;
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, in_m1};
                mplier <= in_m2;
                rem_r  <= '0;
                // Word divides start with the 32-bit dividend at the top so the
                // quotient lands in the low 32 bits after 32 shifts.
                dq     <= in_word ? (in_m1 << (XLEN - 32)) : in_m1;
                dvsr   <= in_m2;
                res_q  <= early_hit ? early_val : '0;
            end else if (state == S_CALC) begin
                cnt    <= cnt - 1'b1;
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                rem_r  <= rem_nx;
                dq     <= dq_nx;
                if (cnt == CW'(1)) res_q <= fin;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_mdu_iter.sv
// Testbench for ysyx_22040895_mdu_iter (XLEN=64): directed corner cases plus
// randomized requests scored against an arithmetic reference model.
module tb_ysyx_22040895_mdu_iter;

    localparam int XLEN     = 64;
    localparam int MAX_WAIT = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      mduop_i;
    logic            wordop_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            flush_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_o;
    logic [1:0]      dbg_state;

    ysyx_22040895_mdu_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mduop_i   (mduop_i),
        .wordop_i  (wordop_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic               wd;
        logic [127:0]       p;
        logic signed [63:0] sa, sb, sq;
        logic [63:0]        ua, ub, r;
        wd = w && !(op inside {4'd2, 4'd3, 4'd4});
        sa = wd ? 64'($signed(a[31:0])) : $signed(a);
        sb = wd ? 64'($signed(b[31:0])) : $signed(b);
        ua = wd ? {32'b0, a[31:0]} : a;
        ub = wd ? {32'b0, b[31:0]} : b;
        r  = 64'd0;
        case (op)
            4'd1: r = a * b;
            4'd2: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            4'd3: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
            4'd4: begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
            4'd5: begin
                if (sb == 0) r = '1;
                else if (!wd && sa == $signed(64'h8000_0000_0000_0000) && sb == -1) r = sa;
                else begin sq = sa / sb; r = sq; end
            end
            4'd6: r = (ub == 0) ? '1 : ua / ub;
            4'd7: begin
                if (sb == 0) r = sa;
                else if (!wd && sa == $signed(64'h8000_0000_0000_0000) && sb == -1) r = 64'd0;
                else begin sq = sa % sb; r = sq; end
            end
            4'd8: r = (ub == 0) ? ua : ua % ub;
            default: r = 64'd0;
        endcase
        if (wd && op != 4'd0 && op <= 4'd8) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Rising edges after the accepting edge until out_valid is seen.
    function automatic int ref_latency(input logic [3:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic wd;
        if (op == 4'd0 || op > 4'd8) return 0;
        wd = w && !(op inside {4'd2, 4'd3, 4'd4});
`ifdef YSYX_22040895_MDU_EARLY_OUT_EN
        if (op >= 4'd5) begin
            if (wd ? (b[31:0] == 32'd0) : (b == 64'd0)) return 0;
            if ((op == 4'd5 || op == 4'd7) &&
                (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
                return 0;
        end
`endif
        return wd ? 32 : 64;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {$urandom, 32'h8000_0000};
            4:       return {$urandom, 32'hFFFF_FFFF};
            5:       return 64'($urandom_range(0, 50));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- driver tasks (call at a negedge) ----------------
    task automatic start_op(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        int k = 0;
        while (!in_ready && k < MAX_WAIT) begin
            @(negedge clk);
            k++;
        end
        check_eq("accept_ready", 64'(in_ready), 64'd1);
        mduop_i  = op;
        wordop_i = w;
        op1_i    = a;
        op2_i    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is observed; ends at a negedge.
    task automatic wait_valid(output int k);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < MAX_WAIT) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        int          k;
        logic [63:0] e_res;
        int          e_lat;
        exp_q.push_back(ref_result(op, w, a, b));
        lat_q.push_back(ref_latency(op, w, a, b));
        start_op(op, w, a, b);
        #1;
        check_eq({tag, "/busy_ready"}, 64'(in_ready), 64'd0);
        wait_valid(k);
        e_res = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        check_eq({tag, "/latency"}, 64'(k), 64'(e_lat));
        check_eq({tag, "/result"}, result_o, e_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "/hold_result"}, result_o, e_res);
            check_eq({tag, "/hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "/idle_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "/idle_result"}, result_o, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mduop_i   = 4'd0;
        wordop_i  = 1'b0;
        op1_i     = '0;
        op2_i     = '0;
        flush_i   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset/in_ready", 64'(in_ready), 64'd1);
        check_eq("reset/out_valid", 64'(out_valid), 64'd0);
        check_eq("reset/result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op("mul_7_m3",  4'd1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("mulhu_max", 4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulh_m1",   4'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulhsu",    4'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulw",      4'd1, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        run_op("divw_ovf",  4'd5, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("remw_ovf",  4'd7, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("div_ovf",   4'd5, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divu_z",    4'd6, 1'b0, 64'd5, 64'd0, 0);
        run_op("rem_z",     4'd7, 1'b0, 64'd5, 64'd0, 0);
        run_op("remuw_z",   4'd8, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 0);
        run_op("div_m7",    4'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
        run_op("rem_m7",    4'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
        run_op("div_hold",  4'd5, 1'b0, 64'd100, 64'd7, 5);
        run_op("none",      4'd0, 1'b0, 64'd9, 64'd9, 1);
        run_op("op_12",     4'd12, 1'b0, 64'd9, 64'd9, 0);

        // Flush in the middle of a divide.
        start_op(4'd5, 1'b0, 64'd100, 64'd7);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_calc/in_ready", 64'(in_ready), 64'd1);
        check_eq("flush_calc/out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("flush_calc/no_valid", 64'(seen), 64'd0);

        // Flush beats a transfer on the same edge.
        mduop_i  = 4'd1;
        op1_i    = 64'd3;
        op2_i    = 64'd4;
        in_valid = 1'b1;
        flush_i  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk);
        check_eq("flush_xfer/in_ready", 64'(in_ready), 64'd1);

        // Flush while a result waits in DONE.
        start_op(4'd1, 1'b0, 64'd3, 64'd5);
        wait_valid(k);
        check_eq("flush_done/result", result_o, ref_result(4'd1, 1'b0, 64'd3, 64'd5));
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_done/out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_done/result0", result_o, 64'd0);

        // Reset mid-CALC.
        start_op(4'd1, 1'b0, 64'd7, 64'd9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_calc/in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_calc/out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_calc/result", result_o, 64'd0);

        // Reset mid-DONE.
        start_op(4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid(k);
        check_eq("rst_done/pre_result", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_done/in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_done/out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_done/result", result_o, 64'd0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  r_op;
            logic        r_w;
            logic [63:0] r_a, r_b;
            r_op = 4'($urandom_range(0, 15));
            r_w  = 1'($urandom_range(0, 1));
            r_a  = pick_operand();
            r_b  = pick_operand();
            run_op($sformatf("rand%0d_op%0d_w%0d", n, r_op, r_w), r_op, r_w, r_a, r_b,
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_mdu_iter.md
YSYX_22040895_MDU_ITER -- requirements
Module: ysyx_22040895_mdu_iter

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 mduop_i  input  4  operation: 0 NONE, 1 MUL, 2 MULH, 3 MULHSU, 4 MULHU, 5 DIV, 6 DIVU, 7 REM, 8 REMU; values 9-15 are treated as NONE.
REQ-007 wordop_i  input  1  32-bit "W" variant; honoured only when XLEN=64.
REQ-008 op1_i, op2_i  input  XLEN  rs1 and rs2 operands.
REQ-009 flush_i  input  1  abort any operation in flight.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result_o  output  XLEN  operation result.

Function
REQ-013 The block SHALL use three states:
- IDLE: in_ready=1, out_valid=0.
- CALC: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-014 A transfer SHALL occur when in_valid and in_ready are both 1 on a clock edge; on that edge op, wordop and both operands are captured.
REQ-015 N SHALL be 32 when wordop applies, otherwise XLEN.
REQ-016 On a transfer the state SHALL go IDLE->CALC with the iteration counter loaded to N.
- Exception: op NONE goes IDLE->DONE with result 0.
REQ-017 In CALC the block SHALL:
- retire one bit per cycle (MUL*: radix-2 shift-add; DIV/REM*: restoring divide);
- decrement the counter each cycle;
- go CALC->DONE on the edge where the counter reaches 0.
REQ-018 out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-019 Signed operations SHALL run on operand magnitudes and apply the sign correction in the final CALC cycle.
- MULHSU: op1 signed, op2 unsigned.
REQ-020 Result selection:
- MUL: low XLEN bits of the product.
- MULH*: high XLEN bits of the 2*XLEN-bit product.
REQ-021 Word ops:
- operate on op[31:0];
- result is the 32-bit result sign-extended from bit 31;
- wordop with MULH/MULHSU/MULHU is ignored (full-width operation).
REQ-022 Divide by zero: quotient = all ones; REM/REMU result = dividend (low 32 bits, sign-extended, for word ops).
REQ-023 Signed overflow (most-negative / -1, within the operating width): DIV result = dividend; REM result = 0.
REQ-024 In DONE, result_o and out_valid SHALL hold stable until out_ready=1.
- The edge with out_ready=1 goes DONE->IDLE.
- A new request is accepted no earlier than the following cycle.
REQ-025 flush_i=1 SHALL force the next state to IDLE from any state, discarding the operation; flush has priority over transfer and completion on the same edge.
REQ-026 result_o SHALL be 0 whenever out_valid=0.

Reset
REQ-027 With rst=1 on an edge, the block SHALL go to IDLE with counter 0, captured operands 0, and result 0.
REQ-028 After that edge, in_ready=1, out_valid=0 and result_o=0.
REQ-029 Reset SHALL override flush, transfer and completion, including reset asserted mid-CALC or mid-DONE.

Configuration
REQ-030 With macro YSYX_22040895_MDU_EARLY_OUT_EN defined, divide-by-zero and signed-overflow requests SHALL go IDLE->DONE directly, with out_valid one cycle after acceptance.
REQ-031 Without YSYX_22040895_MDU_EARLY_OUT_EN, those cases SHALL take the full N-cycle CALC path.
- Result values are identical in both builds.

Verification
REQ-032 XLEN=64, MUL op1=7, op2=-3, out_ready=1 -> out_valid 64 cycles after accept; result 0xFFFFFFFFFFFFFFEB.
REQ-033 MULHU op1=op2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE; MULH same operands -> 0.
REQ-034 DIVW op1=0x80000000, op2=0xFFFFFFFF -> result 0xFFFFFFFF80000000 after 32 cycles; REMW same operands -> 0.
REQ-035 DIVU op1=5, op2=0 -> result 0xFFFFFFFFFFFFFFFF; REM op1=5, op2=0 -> 5.
- Latency is 1 cycle with YSYX_22040895_MDU_EARLY_OUT_EN defined, 64 cycles without.
REQ-036 DIV 100/7 with out_ready=0 for 5 cycles after out_valid -> result 14 held stable, in_ready=0, then IDLE.
- Repeat with flush_i at CALC cycle 10 -> no out_valid; in_ready=1 the next cycle.
REQ-037 rst=1 asserted mid-CALC -> next cycle in_ready=1, out_valid=0, result_o=0.
